phys_reg_free_list: RTL and testbench
=====================================

# phys_reg_free_list

Physical-register allocator and busy-bit scoreboard for the 64-entry renamed register file. It holds unmapped physical register tags in a circular free list. It hands one tag per cycle to the rename stage and accepts one released tag per cycle from commit. It tracks which physical registers await a write-back, so the register file and issue logic can see which operands are not yet produced.

## Interface
Parameters:
- PHYS_REGS, 64, physical registers in the register file
- ARCH_REGS, 32, architectural registers, permanently mapped at reset to physical 0..31
- TAG_W, 6, physical tag width, equal to clog2(PHYS_REGS)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- alloc_req  in  1  rename requests one destination tag this cycle
- alloc_valid  out  1  free list non-empty; alloc_tag is usable
- alloc_tag  out  TAG_W  tag at the list head (show-ahead)
- free_req  in  1  commit releases a previously mapped tag
- free_tag  in  TAG_W  tag being released
- wb_valid  in  1  write-back stage wrote a physical register
- wb_tag  in  TAG_W  physical register written
- busy_bits  out  PHYS_REGS  1 means the register is awaiting its producer
- free_count  out  TAG_W+1  entries currently in the free list
- overflow_err  out  1  sticky: a release arrived while the list was full

## Operation
- The storage is a circular array of DEPTH = PHYS_REGS − ARCH_REGS entries, with head pointer, tail pointer and count. Pointers are clog2(DEPTH) bits wide and wrap naturally at DEPTH.
- Reset state:
  - entry i = ARCH_REGS + i; head = 0, tail = 0, count = DEPTH.
  - busy_bits = 0, overflow_err = 0.
  - Resulting outputs: alloc_valid = 1, alloc_tag = 32, free_count = 32.
- Allocate fires when alloc_req && count != 0:
  - head advances by 1 and count decrements.
  - alloc_req while count == 0 is ignored; no state change.
- Release fires when free_req && count != DEPTH:
  - mem[tail] = free_tag, tail advances by 1, count increments.
  - free_req while full is dropped and sets overflow_err, which holds until rst.
- Simultaneous allocate and release both fire and count is unchanged.
  - If count == 0, the allocate is rejected and the release still fires. There is no same-cycle bypass of free_tag to alloc_tag.
- free_tag == 0 (the $zero mapping) is dropped silently and never enters the list.
- Busy bits:
  - An allocate fire sets busy_bits[alloc_tag].
  - wb_valid clears busy_bits[wb_tag].
  - If the same tag is set and cleared in one cycle, set wins (new producer).
  - Bit 0 is held at 0.

## Timing
- alloc_tag and alloc_valid are combinational from head and count. The rename stage uses the tag in the same cycle it asserts alloc_req.
- A released tag becomes allocatable the cycle after the release edge, at the earliest when the list was empty.
- busy_bits and free_count update at the edge that follows the firing event.
- rst asserted mid-operation immediately restores the reset state, regardless of clk. Any in-flight allocate or release is lost.

## Configuration
- PHYS_BUSY_TRACK_EN defined: the busy-bit scoreboard is built as described above.
- PHYS_BUSY_TRACK_EN undefined:
  - busy_bits is tied to 0 and no scoreboard flops exist.
  - wb_valid and wb_tag are ignored.
  - Free-list behaviour is unchanged.

## Structure
- mips_core_pkg gains:
  - typedef phys_tag_t, a logic vector of TAG_W bits
  - constants PHYS_REGS and ARCH_REGS, shared with reg_file and the rename table
- One sub-module, phys_tag_fifo: the circular array with head, tail and count, and full/empty flags.
- The top level contains the scoreboard, the $zero filter and overflow_err.

## Test plan
- Reset, then 32 consecutive alloc_req with no release → tags 32..63 issued in order. Then alloc_valid = 0, free_count = 0, and busy_bits[63:32] all 1.
- On the empty list, assert alloc_req and free_req(tag 40) together → no allocation this cycle. Next cycle alloc_valid = 1, alloc_tag = 40, free_count = 1.
- With free_count = 5, assert alloc and release simultaneously for 10 cycles → free_count stays 5 and tags come out in FIFO order across pointer wrap.
- With the list full at reset, free_req(tag 7) → overflow_err = 1 and free_count stays 32. overflow_err stays 1 until rst.
- Allocate tag 32 while wb_valid with wb_tag 32 in the same cycle → busy_bits[32] = 1. Later wb_tag 32 → busy_bits[32] = 0. free_req(tag 0) → free_count unchanged.
- Assert rst asynchronously between clock edges mid-stream → outputs return immediately to alloc_tag = 32, free_count = 32, busy_bits = 0.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// Shared physical-register constants and tag type for the rename/allocator slice.
package phys_reg_free_list_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned PHYS_TAG_W    = $clog2(NUM_PHYS_REGS);
    localparam int unsigned FL_DEPTH      = NUM_PHYS_REGS - NUM_ARCH_REGS;

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit/write-back handshake bundle for the physical-register free list.
interface phys_reg_free_list_if
    import phys_reg_free_list_pkg::*;
#(
    parameter int unsigned PHYS_REGS = NUM_PHYS_REGS,
    parameter int unsigned TAG_W     = PHYS_TAG_W
);

    logic                 alloc_req;
    logic                 alloc_valid;
    logic [TAG_W-1:0]     alloc_tag;
    logic                 free_req;
    logic [TAG_W-1:0]     free_tag;
    logic                 wb_valid;
    logic [TAG_W-1:0]     wb_tag;
    logic [PHYS_REGS-1:0] busy_bits;
    logic [TAG_W:0]       free_count;
    logic                 overflow_err;

    // Pipeline side: rename, commit and write-back
    modport master (
        output alloc_req, free_req, free_tag, wb_valid, wb_tag,
        input  alloc_valid, alloc_tag, busy_bits, free_count, overflow_err
    );

    // Allocator side
    modport slave (
        input  alloc_req, free_req, free_tag, wb_valid, wb_tag,
        output alloc_valid, alloc_tag, busy_bits, free_count, overflow_err
    );

endinterface

// File: rtl/phys_reg_free_list_tag_fifo.sv
// phys_tag_fifo: circular tag store with head/tail/count; resets holding BASE..BASE+DEPTH-1.
module phys_tag_fifo #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned BASE  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_data,
    input  logic                       pop,
    output logic [TAG_W-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push_fire_c;
    logic             pop_fire_c;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign push_fire_c = push && !full;
    assign pop_fire_c  = pop && !empty;
    assign head_data   = mem[head];

    // Storage and pointers; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= TAG_W'(BASE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            if (push_fire_c) begin
                mem[tail] <= push_data;
                tail      <= tail + PTR_W'(1);
            end
            if (pop_fire_c) begin
                head <= head + PTR_W'(1);
            end
            case ({push_fire_c, pop_fire_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register allocator: free list, $zero filter, sticky overflow and busy scoreboard.
// Busy-bit scoreboard is built only when PHYS_BUSY_TRACK_EN is defined.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
#(
    parameter int unsigned PHYS_REGS = NUM_PHYS_REGS,
    parameter int unsigned ARCH_REGS = NUM_ARCH_REGS,
    parameter int unsigned TAG_W     = $clog2(PHYS_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    phys_reg_free_list_if.slave fl
);

    localparam int unsigned DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned FC_W  = TAG_W + 1;

    logic [TAG_W-1:0] head_tag;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             alloc_fire_c;
    logic             release_c;
    logic             overflow_q;

    // Tag 0 is the permanent $zero mapping and must never be recycled
    assign release_c    = fl.free_req && (fl.free_tag != '0);
    assign alloc_fire_c = fl.alloc_req && !empty;

    phys_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .BASE  (ARCH_REGS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (release_c),
        .push_data (fl.free_tag),
        .pop       (fl.alloc_req),
        .head_data (head_tag),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign fl.alloc_valid  = !empty;
    assign fl.alloc_tag    = head_tag;
    assign fl.free_count   = FC_W'(count);
    assign fl.overflow_err = overflow_q;

    // Sticky release-while-full indicator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (release_c && full) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef PHYS_BUSY_TRACK_EN
    logic [PHYS_REGS-1:0] busy_q;
    logic [PHYS_REGS-1:0] busy_next_c;

    // Set from a new allocation overrides a same-cycle write-back clear
    always_comb begin
        busy_next_c = busy_q;
        if (fl.wb_valid) begin
            busy_next_c[fl.wb_tag] = 1'b0;
        end
        if (alloc_fire_c) begin
            busy_next_c[head_tag] = 1'b1;
        end
        busy_next_c[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next_c;
        end
    end

    assign fl.busy_bits = busy_q;
`else
    logic unused_wb_c;

    assign unused_wb_c  = ^{fl.wb_valid, fl.wb_tag, alloc_fire_c};
    assign fl.busy_bits = '0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed vectors, corner sequences, random vs queue model.
module tb_phys_reg_free_list;

`ifdef PHYS_BUSY_TRACK_EN
    localparam bit BUSY_EN = 1'b1;
`else
    localparam bit BUSY_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    phys_reg_free_list_if fl_if ();

    phys_reg_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: free list as a plain queue, busy as a bit array
    int       m_q[$];
    bit [63:0] m_busy;
    bit        m_ovf;

    typedef struct {
        bit         alloc;
        bit         free;
        logic [5:0] ftag;
        int         e_cnt;
        int         e_tag;
        bit         e_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 32; i < 64; i++) m_q.push_back(i);
        m_busy = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit f, input int ft, input bit w, input int wt);
        int sz;
        int t;
        sz = m_q.size();
        if (BUSY_EN && w) m_busy[wt] = 1'b0;
        if (a && sz != 0) begin
            t = m_q.pop_front();
            if (BUSY_EN) m_busy[t] = 1'b1;
        end
        if (f && ft != 0) begin
            if (sz == 32) m_ovf = 1'b1;
            else m_q.push_back(ft);
        end
        m_busy[0] = 1'b0;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_count"}, 64'(fl_if.free_count), 64'(m_q.size()));
        chk({pfx, "_valid"}, 64'(fl_if.alloc_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk({pfx, "_tag"}, 64'(fl_if.alloc_tag), 64'(m_q[0]));
        chk({pfx, "_busy"}, fl_if.busy_bits, m_busy);
        chk({pfx, "_ovf"}, 64'(fl_if.overflow_err), 64'(m_ovf));
    endtask

    // One clock: drive at posedge+1, step the model at the edge, check at posedge+1
    task automatic cyc(input bit a, input bit f, input int ft, input bit w, input int wt,
                       input string pfx);
        fl_if.alloc_req = a;
        fl_if.free_req  = f;
        fl_if.free_tag  = 6'(ft);
        fl_if.wb_valid  = w;
        fl_if.wb_tag    = 6'(wt);
        @(posedge clk);
        model_step(a, f, ft, w, wt);
        #1;
        fl_if.alloc_req = 1'b0;
        fl_if.free_req  = 1'b0;
        fl_if.wb_valid  = 1'b0;
        check_all(pfx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int exp_order[$];
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        fl_if.alloc_req = 1'b0;
        fl_if.free_req  = 1'b0;
        fl_if.free_tag  = '0;
        fl_if.wb_valid  = 1'b0;
        fl_if.wb_tag    = '0;

        vecs[0] = '{1'b1, 1'b0, 6'd0,  31, 33, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 6'd5,  31, 34, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 6'd0,  31, 34, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 6'd9,  32, 34, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 6'd11, 32, 34, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 6'd0,  31, 35, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 6'd0,  30, 36, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 6'd12, 31, 36, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_tag", 64'(fl_if.alloc_tag), 64'd32);
        chk("reset_cnt", 64'(fl_if.free_count), 64'd32);

        // Directed vector table
        foreach (vecs[i]) begin
            cyc(vecs[i].alloc, vecs[i].free, int'(vecs[i].ftag), 1'b0, 0, "vec");
            chk($sformatf("vec%0d_cnt", i), 64'(fl_if.free_count), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_tag", i), 64'(fl_if.alloc_tag), 64'(vecs[i].e_tag));
            chk($sformatf("vec%0d_ovf", i), 64'(fl_if.overflow_err), 64'(vecs[i].e_ovf));
        end

        // Drain all 32 tags in order
        do_reset();
        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", 64'(fl_if.alloc_tag), 64'(32 + i));
            cyc(1'b1, 1'b0, 0, 1'b0, 0, "drain");
        end
        chk("empty_valid", 64'(fl_if.alloc_valid), 64'd0);
        chk("empty_cnt", 64'(fl_if.free_count), 64'd0);
        chk("empty_busy_hi", 64'(fl_if.busy_bits[63:32]), BUSY_EN ? 64'hFFFF_FFFF : 64'd0);

        // Empty list: allocate rejected, release still lands
        cyc(1'b1, 1'b1, 40, 1'b0, 0, "empty_rel");
        chk("empty_rel_valid", 64'(fl_if.alloc_valid), 64'd1);
        chk("empty_rel_tag", 64'(fl_if.alloc_tag), 64'd40);
        chk("empty_rel_cnt", 64'(fl_if.free_count), 64'd1);

        // Steady state at five entries, FIFO order preserved
        for (int t = 41; t <= 44; t++) cyc(1'b0, 1'b1, t, 1'b0, 0, "fill5");
        for (int t = 40; t <= 44; t++) exp_order.push_back(t);
        for (int i = 0; i < 10; i++) begin
            chk("steady_tag", 64'(fl_if.alloc_tag), 64'(exp_order.pop_front()));
            exp_order.push_back(50 + i);
            cyc(1'b1, 1'b1, 50 + i, 1'b0, 0, "steady");
            chk("steady_cnt", 64'(fl_if.free_count), 64'd5);
        end

        // Release into a full list
        do_reset();
        cyc(1'b0, 1'b1, 7, 1'b0, 0, "ovf");
        chk("ovf_set", 64'(fl_if.overflow_err), 64'd1);
        chk("ovf_cnt", 64'(fl_if.free_count), 64'd32);
        repeat (3) cyc(1'b1, 1'b1, 9, 1'b0, 0, "ovf_hold");
        chk("ovf_sticky", 64'(fl_if.overflow_err), 64'd1);
        do_reset();
        chk("ovf_clear", 64'(fl_if.overflow_err), 64'd0);

        // Same-cycle set/clear of a busy bit, later clear, $zero release
        cyc(1'b1, 1'b0, 0, 1'b1, 32, "busy_set");
        chk("busy32_set", 64'(fl_if.busy_bits[32]), 64'(BUSY_EN));
        cyc(1'b0, 1'b0, 0, 1'b1, 32, "busy_clr");
        chk("busy32_clr", 64'(fl_if.busy_bits[32]), 64'd0);
        cyc(1'b0, 1'b1, 0, 1'b0, 0, "zero_rel");
        chk("zero_rel_cnt", 64'(fl_if.free_count), 64'd31);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                int'($urandom_range(0, 63)), $urandom_range(0, 99) < 40,
                int'($urandom_range(0, 63)), "rand");
        end

        // Asynchronous reset between edges
        repeat (5) cyc(1'b1, 1'b0, 0, 1'b0, 0, "pre_arst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tag", 64'(fl_if.alloc_tag), 64'd32);
        chk("arst_cnt", 64'(fl_if.free_count), 64'd32);
        chk("arst_busy", fl_if.busy_bits, 64'd0);
        chk("arst_valid", 64'(fl_if.alloc_valid), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("post_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
